// File: rtl/bp_resolve_ctrl_if.sv
// Handshake and status bundle between IF/EX and the branch-resolution controller.
// The master side drives predictions and resolutions; the slave side is the controller.
interface bp_resolve_ctrl_if #(
    parameter int word_width = 32,
    parameter int depth      = 4
);
    localparam int CW = $clog2(depth) + 1;

    logic                  pred_valid;
    logic                  pred_taken;
    logic [word_width-1:0] pred_target;
    logic [word_width-1:0] pred_fallthrough;
    logic                  pred_ready;
    logic                  res_valid;
    logic                  res_taken;
    logic [word_width-1:0] res_target;
    logic [word_width-1:0] bp_addr_d;
    logic                  bp_addr_en;
    logic                  redirect_valid;
    logic [word_width-1:0] redirect_addr;
    logic                  flush;
    logic [CW-1:0]         count;
    logic [15:0]           mispredict_count;
    logic                  protocol_err;

    modport master (
        output pred_valid, pred_taken, pred_target, pred_fallthrough,
        output res_valid, res_taken, res_target,
        input  pred_ready, bp_addr_d, bp_addr_en, redirect_valid, redirect_addr,
        input  flush, count, mispredict_count, protocol_err
    );

    modport slave (
        input  pred_valid, pred_taken, pred_target, pred_fallthrough,
        input  res_valid, res_taken, res_target,
        output pred_ready, bp_addr_d, bp_addr_en, redirect_valid, redirect_addr,
        output flush, count, mispredict_count, protocol_err
    );
endinterface

// File: rtl/bp_resolve_ctrl.sv
// In-order tracker of predicted branches: checks EX resolutions against the queue head,
// and on a mispredict loads the recovery address, then runs a timed flush plus a one-shot redirect.
module bp_resolve_ctrl #(
    parameter int word_width   = 32,
    parameter int depth        = 4,
    parameter int flush_cycles = 2
) (
    input  logic              clk,
    input  logic              reset,
    bp_resolve_ctrl_if.slave  bus
);
    localparam int PW = $clog2(depth);
    localparam int FW = $clog2(flush_cycles + 1);
    localparam logic [PW:0]   DEPTH_C = (PW+1)'(depth);
    localparam logic [FW-1:0] FLUSH_C = FW'(flush_cycles);

    typedef enum logic [1:0] {IDLE, TRACK, FLUSH} state_t;

    state_t                state_q, state_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [PW:0]           count_q, count_d;
    logic [FW-1:0]         fcnt_q, fcnt_d;
    logic [word_width-1:0] recov_q, recov_d;
    logic [15:0]           misp_cnt_q, misp_cnt_d;
    logic                  perr_q, perr_d;

    logic                  taken_mem  [depth];
    logic [word_width-1:0] target_mem [depth];
    logic [word_width-1:0] ft_mem     [depth];

    logic                  ready;
    logic                  push;
    logic                  res_act;
    logic                  mispred;
    logic                  pop;
    logic [word_width-1:0] recov;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Handshake and head comparison; resolutions are ignored while flushing.
    always_comb begin
        ready   = (state_q != FLUSH) && (count_q < DEPTH_C);
        push    = bus.pred_valid && ready;
        res_act = bus.res_valid && (state_q != FLUSH) && (count_q != '0);
        mispred = res_act &&
                  ((bus.res_taken != taken_mem[rd_ptr_q]) ||
                   (bus.res_taken && (bus.res_target != target_mem[rd_ptr_q])));
        pop     = res_act && !mispred;
        recov   = bus.res_taken ? bus.res_target : ft_mem[rd_ptr_q];
    end

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        fcnt_d     = fcnt_q;
        recov_d    = recov_q;
        misp_cnt_d = misp_cnt_q;
        perr_d     = perr_q || (bus.res_valid && (state_q != FLUSH) && (count_q == '0));
        case (state_q)
            FLUSH: begin
                fcnt_d = fcnt_q - FW'(1);
                if (fcnt_q == FW'(1)) state_d = IDLE;
            end
            default: begin
                if (mispred) begin
                    // Clearing the queue also discards any push accepted this cycle.
                    state_d    = FLUSH;
                    fcnt_d     = FLUSH_C;
                    wr_ptr_d   = '0;
                    rd_ptr_d   = '0;
                    count_d    = '0;
                    recov_d    = recov;
                    misp_cnt_d = sat_inc16(misp_cnt_q);
                end else begin
                    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
                    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
                    count_d = count_q + (PW+1)'(push) - (PW+1)'(pop);
                    state_d = (count_d == '0) ? IDLE : TRACK;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            fcnt_q     <= '0;
            recov_q    <= '0;
            misp_cnt_q <= '0;
            perr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            fcnt_q     <= fcnt_d;
            recov_q    <= recov_d;
            misp_cnt_q <= misp_cnt_d;
            perr_q     <= perr_d;
        end
    end

    // Queue payload carries no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            taken_mem[wr_ptr_q]  <= bus.pred_taken;
            target_mem[wr_ptr_q] <= bus.pred_target;
            ft_mem[wr_ptr_q]     <= bus.pred_fallthrough;
        end
    end

    assign bus.pred_ready       = ready;
    assign bus.bp_addr_en       = mispred;
    assign bus.bp_addr_d        = mispred ? recov : '0;
    assign bus.redirect_valid   = (state_q == FLUSH) && (fcnt_q == FLUSH_C);
    assign bus.redirect_addr    = recov_q;
    assign bus.flush            = (state_q == FLUSH);
    assign bus.count            = count_q;
    assign bus.mispredict_count = misp_cnt_q;
    assign bus.protocol_err     = perr_q;
endmodule

// File: tb/tb_bp_resolve_ctrl.sv
// Directed bench for bp_resolve_ctrl: a per-cycle vector table plus hand-written
// sequences for pointer wrap, reset during flush and counter saturation.
module tb_bp_resolve_ctrl;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    bp_resolve_ctrl_if #(.word_width(32), .depth(4)) bus ();

    bp_resolve_ctrl #(.word_width(32), .depth(4), .flush_cycles(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic        pv;
        logic        pt;
        logic [31:0] ptgt;
        logic [31:0] pft;
        logic        rv;
        logic        rt;
        logic [31:0] rtgt;
        logic        rdy;
        logic        en;
        logic [31:0] d;
        logic        rdv;
        logic [31:0] ra;
        logic        fl;
        logic [2:0]  cnt;
        logic [15:0] mc;
        logic        pe;
    } vec_t;

    vec_t tbl[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic vec_t mk(logic pv, logic pt, logic [31:0] ptgt, logic [31:0] pft,
                                logic rv, logic rt, logic [31:0] rtgt,
                                logic rdy, logic en, logic [31:0] d, logic rdv, logic [31:0] ra,
                                logic fl, logic [2:0] cnt, logic [15:0] mc, logic pe);
        vec_t v;
        v.pv = pv;  v.pt = pt;  v.ptgt = ptgt; v.pft = pft;
        v.rv = rv;  v.rt = rt;  v.rtgt = rtgt;
        v.rdy = rdy; v.en = en; v.d = d; v.rdv = rdv; v.ra = ra;
        v.fl = fl;  v.cnt = cnt; v.mc = mc; v.pe = pe;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic pv, input logic pt, input logic [31:0] ptgt,
                         input logic [31:0] pft, input logic rv, input logic rt,
                         input logic [31:0] rtgt);
        bus.pred_valid       = pv;
        bus.pred_taken       = pt;
        bus.pred_target      = ptgt;
        bus.pred_fallthrough = pft;
        bus.res_valid        = rv;
        bus.res_taken        = rt;
        bus.res_target       = rtgt;
    endtask

    task automatic cyc(input logic pv, input logic pt, input logic [31:0] ptgt,
                       input logic [31:0] pft, input logic rv, input logic rt,
                       input logic [31:0] rtgt);
        @(negedge clk);
        drive(pv, pt, ptgt, pft, rv, rt, rtgt);
        #1;
    endtask

    task automatic check_vec(input string tag, input vec_t v);
        chk({tag, ".pred_ready"},       32'(bus.pred_ready),       32'(v.rdy));
        chk({tag, ".bp_addr_en"},       32'(bus.bp_addr_en),       32'(v.en));
        chk({tag, ".bp_addr_d"},        bus.bp_addr_d,             v.d);
        chk({tag, ".redirect_valid"},   32'(bus.redirect_valid),   32'(v.rdv));
        chk({tag, ".redirect_addr"},    bus.redirect_addr,         v.ra);
        chk({tag, ".flush"},            32'(bus.flush),            32'(v.fl));
        chk({tag, ".count"},            32'(bus.count),            32'(v.cnt));
        chk({tag, ".mispredict_count"}, 32'(bus.mispredict_count), 32'(v.mc));
        chk({tag, ".protocol_err"},     32'(bus.protocol_err),     32'(v.pe));
    endtask

    initial begin
        //        pv pt ptgt      pft     rv rt rtgt     | rdy en d        rdv ra      fl cnt mc pe
        tbl.push_back(mk(0,0,32'h0,    32'h0,  0,0,32'h0,    1,0,32'h0,  0,32'h0,  0,0,0,0)); // 0
        tbl.push_back(mk(1,1,32'h100,  32'h14, 0,0,32'h0,    1,0,32'h0,  0,32'h0,  0,0,0,0)); // 1
        tbl.push_back(mk(1,1,32'h200,  32'h24, 0,0,32'h0,    1,0,32'h0,  0,32'h0,  0,1,0,0)); // 2
        tbl.push_back(mk(1,1,32'h300,  32'h34, 0,0,32'h0,    1,0,32'h0,  0,32'h0,  0,2,0,0)); // 3
        tbl.push_back(mk(0,0,32'h0,    32'h0,  1,1,32'h100,  1,0,32'h0,  0,32'h0,  0,3,0,0)); // 4
        tbl.push_back(mk(0,0,32'h0,    32'h0,  1,1,32'h200,  1,0,32'h0,  0,32'h0,  0,2,0,0)); // 5
        tbl.push_back(mk(0,0,32'h0,    32'h0,  1,1,32'h300,  1,0,32'h0,  0,32'h0,  0,1,0,0)); // 6
        tbl.push_back(mk(0,0,32'h0,    32'h0,  0,0,32'h0,    1,0,32'h0,  0,32'h0,  0,0,0,0)); // 7
        tbl.push_back(mk(1,1,32'h100,  32'h14, 0,0,32'h0,    1,0,32'h0,  0,32'h0,  0,0,0,0)); // 8
        tbl.push_back(mk(0,0,32'h0,    32'h0,  1,0,32'h0,    1,1,32'h14, 0,32'h0,  0,1,0,0)); // 9
        tbl.push_back(mk(0,0,32'h0,    32'h0,  0,0,32'h0,    0,0,32'h0,  1,32'h14, 1,0,1,0)); // 10
        tbl.push_back(mk(0,0,32'h0,    32'h0,  0,0,32'h0,    0,0,32'h0,  0,32'h14, 1,0,1,0)); // 11
        tbl.push_back(mk(0,0,32'h0,    32'h0,  0,0,32'h0,    1,0,32'h0,  0,32'h14, 0,0,1,0)); // 12
        tbl.push_back(mk(1,1,32'h100,  32'h14, 0,0,32'h0,    1,0,32'h0,  0,32'h14, 0,0,1,0)); // 13
        tbl.push_back(mk(1,1,32'h600,  32'h64, 1,1,32'h180,  1,1,32'h180,0,32'h14, 0,1,1,0)); // 14
        tbl.push_back(mk(1,1,32'h500,  32'h54, 1,1,32'h500,  0,0,32'h0,  1,32'h180,1,0,2,0)); // 15
        tbl.push_back(mk(1,1,32'h500,  32'h54, 1,1,32'h500,  0,0,32'h0,  0,32'h180,1,0,2,0)); // 16
        tbl.push_back(mk(0,0,32'h0,    32'h0,  0,0,32'h0,    1,0,32'h0,  0,32'h180,0,0,2,0)); // 17
        tbl.push_back(mk(1,1,32'h1000, 32'h10, 0,0,32'h0,    1,0,32'h0,  0,32'h180,0,0,2,0)); // 18
        tbl.push_back(mk(1,0,32'h2000, 32'h20, 0,0,32'h0,    1,0,32'h0,  0,32'h180,0,1,2,0)); // 19
        tbl.push_back(mk(1,1,32'h3000, 32'h30, 1,1,32'h1000, 1,0,32'h0,  0,32'h180,0,2,2,0)); // 20
        tbl.push_back(mk(1,1,32'h4000, 32'h40, 0,0,32'h0,    1,0,32'h0,  0,32'h180,0,2,2,0)); // 21
        tbl.push_back(mk(1,1,32'h5000, 32'h50, 0,0,32'h0,    1,0,32'h0,  0,32'h180,0,3,2,0)); // 22
        tbl.push_back(mk(1,1,32'h6000, 32'h60, 1,0,32'h9999, 0,0,32'h0,  0,32'h180,0,4,2,0)); // 23
        tbl.push_back(mk(0,0,32'h0,    32'h0,  1,1,32'h3000, 1,0,32'h0,  0,32'h180,0,3,2,0)); // 24
        tbl.push_back(mk(0,0,32'h0,    32'h0,  1,1,32'h4000, 1,0,32'h0,  0,32'h180,0,2,2,0)); // 25
        tbl.push_back(mk(0,0,32'h0,    32'h0,  1,1,32'h5000, 1,0,32'h0,  0,32'h180,0,1,2,0)); // 26
        tbl.push_back(mk(0,0,32'h0,    32'h0,  0,0,32'h0,    1,0,32'h0,  0,32'h180,0,0,2,0)); // 27
        tbl.push_back(mk(0,0,32'h0,    32'h0,  1,1,32'h100,  1,0,32'h0,  0,32'h180,0,0,2,0)); // 28
        tbl.push_back(mk(0,0,32'h0,    32'h0,  0,0,32'h0,    1,0,32'h0,  0,32'h180,0,0,2,1)); // 29
        tbl.push_back(mk(0,0,32'h0,    32'h0,  0,0,32'h0,    1,0,32'h0,  0,32'h180,0,0,2,1)); // 30

        reset = 1'b0;
        drive(0, 0, 32'h0, 32'h0, 0, 0, 32'h0);
        #2;
        check_vec("reset", mk(0,0,0,0,0,0,0, 1,0,32'h0,0,32'h0,0,0,0,0));
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            cyc(tbl[i].pv, tbl[i].pt, tbl[i].ptgt, tbl[i].pft, tbl[i].rv, tbl[i].rt, tbl[i].rtgt);
            check_vec($sformatf("vec%0d", i), tbl[i]);
        end

        // Six overlapped push/pop rounds carry the pointers past the wrap point.
        cyc(1, 1, 32'h7000, 32'h70, 0, 0, 32'h0);
        chk("wrap.count0", 32'(bus.count), 32'd0);
        cyc(1, 1, 32'h7100, 32'h71, 0, 0, 32'h0);
        chk("wrap.count1", 32'(bus.count), 32'd1);
        for (int i = 2; i < 8; i++) begin
            cyc(1, 1, 32'h7000 + 32'(i) * 32'h100, 32'h70 + 32'(i), 1, 1, 32'h7000 + 32'(i - 2) * 32'h100);
            chk($sformatf("wrap%0d.bp_addr_en", i), 32'(bus.bp_addr_en), 32'd0);
            chk($sformatf("wrap%0d.count", i), 32'(bus.count), 32'd2);
        end
        cyc(0, 0, 32'h0, 32'h0, 1, 1, 32'h7600);
        chk("wrap.tail6.bp_addr_en", 32'(bus.bp_addr_en), 32'd0);
        cyc(0, 0, 32'h0, 32'h0, 1, 1, 32'h7700);
        chk("wrap.tail7.bp_addr_en", 32'(bus.bp_addr_en), 32'd0);
        chk("wrap.tail7.count", 32'(bus.count), 32'd1);
        cyc(0, 0, 32'h0, 32'h0, 0, 0, 32'h0);
        chk("wrap.end.count", 32'(bus.count), 32'd0);
        chk("wrap.end.mispredict_count", 32'(bus.mispredict_count), 32'd2);

        // Reset pulled low in the middle of a flush.
        cyc(1, 1, 32'h100, 32'h14, 0, 0, 32'h0);
        cyc(0, 0, 32'h0, 32'h0, 1, 0, 32'h0);
        chk("rstflush.bp_addr_en", 32'(bus.bp_addr_en), 32'd1);
        cyc(0, 0, 32'h0, 32'h0, 0, 0, 32'h0);
        chk("rstflush.flush_before", 32'(bus.flush), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check_vec("rstflush.during", mk(0,0,0,0,0,0,0, 1,0,32'h0,0,32'h0,0,0,0,0));
        @(negedge clk);
        reset = 1'b1;
        cyc(0, 0, 32'h0, 32'h0, 0, 0, 32'h0);
        check_vec("rstflush.after", mk(0,0,0,0,0,0,0, 1,0,32'h0,0,32'h0,0,0,0,0));

        // Saturation of the mispredict counter.
        @(negedge clk);
        force dut.misp_cnt_q = 16'hFFFE;
        #1;
        release dut.misp_cnt_q;
        #1;
        chk("sat.preload", 32'(bus.mispredict_count), 32'hFFFE);
        cyc(1, 0, 32'h800, 32'h84, 0, 0, 32'h0);
        cyc(0, 0, 32'h0, 32'h0, 1, 1, 32'h900);
        chk("sat.m1.bp_addr_d", bus.bp_addr_d, 32'h900);
        cyc(0, 0, 32'h0, 32'h0, 0, 0, 32'h0);
        chk("sat.m1.count", 32'(bus.mispredict_count), 32'hFFFF);
        chk("sat.m1.redirect_addr", bus.redirect_addr, 32'h900);
        cyc(0, 0, 32'h0, 32'h0, 0, 0, 32'h0);
        cyc(0, 0, 32'h0, 32'h0, 0, 0, 32'h0);
        chk("sat.ready_back", 32'(bus.pred_ready), 32'd1);
        cyc(1, 1, 32'hA00, 32'hA4, 0, 0, 32'h0);
        cyc(0, 0, 32'h0, 32'h0, 1, 0, 32'h0);
        chk("sat.m2.bp_addr_d", bus.bp_addr_d, 32'hA4);
        cyc(0, 0, 32'h0, 32'h0, 0, 0, 32'h0);
        chk("sat.m2.count", 32'(bus.mispredict_count), 32'hFFFF);
        chk("sat.m2.protocol_err", 32'(bus.protocol_err), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
